// File: rtl/gesture_pkg.sv
// rtl/gesture_pkg.sv - shared types and constants for the gesture UART reporter
package gesture_pkg;

   typedef enum logic [1:0] {
      GESTURE_UP    = 2'b00,
      GESTURE_DOWN  = 2'b01,
      GESTURE_LEFT  = 2'b10,
      GESTURE_RIGHT = 2'b11
   } gesture_t;

   localparam logic [7:0] PKT_HEADER = 8'hA5;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 LSB-first byte serializer
// ready is also high in the last stop-bit cycle, so a following byte starts back-to-back.
module uart_tx_byte
   import gesture_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   tx_state_t     state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    data_q, data_d;
   logic          tx_q, tx_d;
   logic          last_tick;

   assign last_tick = (baud_q == BAUD_LAST);
   assign ready     = (state_q == TX_IDLE) || ((state_q == TX_STOP) && last_tick);
   assign tx        = tx_q;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      data_d  = data_q;
      tx_d    = tx_q;
      if (state_q != TX_IDLE) begin
         baud_d = last_tick ? '0 : baud_q + BW'(1);
      end
      case (state_q)
         TX_IDLE: tx_d = 1'b1;
         TX_START: begin
            if (last_tick) begin
               state_d = TX_DATA;
               bit_d   = 3'd0;
               tx_d    = data_q[0];
            end
         end
         TX_DATA: begin
            if (last_tick) begin
               if (bit_q == 3'd7) begin
                  state_d = TX_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = data_q[bit_q + 3'd1];
               end
            end
         end
         TX_STOP: begin
            if (last_tick) begin
               state_d = TX_IDLE;
               tx_d    = 1'b1;
            end
         end
         default: state_d = TX_IDLE;
      endcase
      if (start && ready) begin
         state_d = TX_START;
         baud_d  = '0;
         data_d  = data;
         tx_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= TX_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: rtl/gesture_uart_reporter.sv
// rtl/gesture_uart_reporter.sv - gesture confirmation, cooldown and 2-byte UART packet sequencer
module gesture_uart_reporter
   import gesture_pkg::*;
#(
   parameter int CLKS_PER_BIT     = 104,
   parameter int CONFIRM_COUNT    = 2,
   parameter int COOLDOWN_WINDOWS = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] gesture,
   input  logic       valid,
   input  logic       pass,
   output logic       uart_tx,
   output logic       busy,
   output logic       report_strobe,
   output logic [1:0] reported_gesture,
   output logic       dropped
);

   localparam logic [3:0] CONFIRM_L  = 4'(CONFIRM_COUNT);
   localparam logic [3:0] COOLDOWN_L = 4'(COOLDOWN_WINDOWS);

   gesture_t   cand_q, cand_d, rep_q, rep_d, in_gesture;
   logic [3:0] cnt_q, cnt_d, cooldown_q, cooldown_d, seq_q, seq_d;
   logic [7:0] byte1_q, byte1_d;
   logic       busy_q, busy_d, byte_sel_q, byte_sel_d;
   logic       strobe_q, strobe_d, dropped_q, dropped_d;
   logic       confirm, ser_start, ser_ready;
   logic [7:0] ser_data;

   always_comb begin
      in_gesture = gesture_t'(gesture);
      cand_d     = cand_q;
      cnt_d      = cnt_q;
      cooldown_d = cooldown_q;
      seq_d      = seq_q;
      byte1_d    = byte1_q;
      busy_d     = busy_q;
      byte_sel_d = byte_sel_q;
      rep_d      = rep_q;
      strobe_d   = 1'b0;
      dropped_d  = 1'b0;
      confirm    = 1'b0;
      ser_start  = 1'b0;
      ser_data   = PKT_HEADER;

      // A saturated count never refires; only a fresh streak reaching the target does.
      if (valid) begin
         if (cooldown_q != 4'd0) begin
            cooldown_d = cooldown_q - 4'd1;
         end else if (!pass) begin
            cnt_d = 4'd0;
         end else if ((cnt_q == 4'd0) || (in_gesture != cand_q)) begin
            cand_d  = in_gesture;
            cnt_d   = 4'd1;
            confirm = (CONFIRM_L == 4'd1);
         end else if (cnt_q != CONFIRM_L) begin
            cnt_d   = cnt_q + 4'd1;
            confirm = (cnt_d == CONFIRM_L);
         end
      end

      if (busy_q && ser_ready) begin
         if (!byte_sel_q) begin
            ser_start  = 1'b1;
            ser_data   = byte1_q;
            byte_sel_d = 1'b1;
         end else begin
            busy_d = 1'b0;
         end
      end

      if (confirm) begin
         if (!busy_q) begin
            ser_start  = 1'b1;
            ser_data   = PKT_HEADER;
            busy_d     = 1'b1;
            byte_sel_d = 1'b0;
            strobe_d   = 1'b1;
            rep_d      = cand_d;
            byte1_d    = {seq_q, 2'b00, cand_d};
            seq_d      = seq_q + 4'd1;
            cooldown_d = COOLDOWN_L;
            cnt_d      = 4'd0;
         end else begin
            dropped_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cand_q     <= GESTURE_UP;
         cnt_q      <= '0;
         cooldown_q <= '0;
         seq_q      <= '0;
         byte1_q    <= '0;
         busy_q     <= 1'b0;
         byte_sel_q <= 1'b0;
         rep_q      <= GESTURE_UP;
         strobe_q   <= 1'b0;
         dropped_q  <= 1'b0;
      end else begin
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         cooldown_q <= cooldown_d;
         seq_q      <= seq_d;
         byte1_q    <= byte1_d;
         busy_q     <= busy_d;
         byte_sel_q <= byte_sel_d;
         rep_q      <= rep_d;
         strobe_q   <= strobe_d;
         dropped_q  <= dropped_d;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk  (clk),
      .rst  (rst),
      .start(ser_start),
      .data (ser_data),
      .tx   (uart_tx),
      .ready(ser_ready)
   );

   assign busy             = busy_q;
   assign report_strobe    = strobe_q;
   assign reported_gesture = rep_q;
   assign dropped          = dropped_q;

endmodule

// File: tb/tb_gesture_uart_reporter.sv
// tb/tb_gesture_uart_reporter.sv - directed self-checking bench for gesture_uart_reporter
module tb_gesture_uart_reporter;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] gesture = 2'd0, g0 = 2'd0;
   logic       valid = 1'b0, pass = 1'b0, v0 = 1'b0, p0 = 1'b0;
   logic       tx, busy, strobe, dropped;
   logic [1:0] rep;
   logic       tx0, busy0, strobe0, dropped0;
   logic [1:0] rep0;
   logic       arr [0:199];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   gesture_uart_reporter #(.CLKS_PER_BIT(CPB), .CONFIRM_COUNT(2), .COOLDOWN_WINDOWS(3)) dut (
      .clk(clk), .rst(rst), .gesture(gesture), .valid(valid), .pass(pass),
      .uart_tx(tx), .busy(busy), .report_strobe(strobe), .reported_gesture(rep), .dropped(dropped)
   );

   gesture_uart_reporter #(.CLKS_PER_BIT(CPB), .CONFIRM_COUNT(2), .COOLDOWN_WINDOWS(0)) dut0 (
      .clk(clk), .rst(rst), .gesture(g0), .valid(v0), .pass(p0),
      .uart_tx(tx0), .busy(busy0), .report_strobe(strobe0), .reported_gesture(rep0), .dropped(dropped0)
   );

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; valid = 1'b0; v0 = 1'b0; pass = 1'b0; p0 = 1'b0; gesture = 2'd0; g0 = 2'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse(input bit sel, input logic [1:0] g, input logic p);
      @(negedge clk);
      if (sel) begin g0 = g; p0 = p; v0 = 1'b1; end
      else begin gesture = g; pass = p; valid = 1'b1; end
      @(negedge clk);
      v0 = 1'b0; valid = 1'b0;
   endtask

   task automatic get_frame(input bit sel, output logic [7:0] b0, output logic [7:0] b1, output int len);
      for (int i = 0; i < 200; i++) arr[i] = 1'bx;
      len = 0;
      while ((sel ? busy0 : busy) && len < 200) begin
         arr[len] = sel ? tx0 : tx;
         len++;
         @(negedge clk);
      end
      for (int i = 0; i < 8; i++) begin
         b0[i] = arr[CPB * (i + 1) + CPB / 2];
         b1[i] = arr[CPB * (i + 11) + CPB / 2];
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({tx, busy, strobe, dropped} !== 4'b1000) begin
         errors++; $display("FAIL reset_outputs: got %b expected 1000", {tx, busy, strobe, dropped});
      end
      checks++;
      if (rep !== 2'b00) begin
         errors++; $display("FAIL reset_gesture: got %b expected 00", rep);
      end
      checks++;
      if ({tx0, busy0} !== 2'b10) begin
         errors++; $display("FAIL reset_dut0: got %b expected 10", {tx0, busy0});
      end
   endtask

   task automatic test_basic();
      logic [7:0] b0, b1;
      int len;
      do_reset();
      pulse(0, 2'd3, 1'b1);
      checks++;
      if (strobe !== 1'b0) begin errors++; $display("FAIL basic_early_strobe: got %b expected 0", strobe); end
      repeat (8) @(negedge clk);
      pulse(0, 2'd3, 1'b1);
      checks++;
      if ({strobe, rep, tx} !== 4'b1110) begin
         errors++; $display("FAIL basic_launch: got %b expected 1110", {strobe, rep, tx});
      end
      get_frame(0, b0, b1, len);
      checks++;
      if (b0 !== 8'hA5) begin errors++; $display("FAIL basic_byte0: got %h expected a5", b0); end
      checks++;
      if (b1 !== 8'h03) begin errors++; $display("FAIL basic_byte1: got %h expected 03", b1); end
      checks++;
      if (len !== 80) begin errors++; $display("FAIL basic_busy_len: got %0d expected 80", len); end
      checks++;
      if ({arr[1], arr[37], arr[41], arr[77], tx} !== 5'b01011) begin
         errors++; $display("FAIL basic_framing: got %b expected 01011", {arr[1], arr[37], arr[41], arr[77], tx});
      end
   endtask

   task automatic test_switch_cooldown();
      logic [7:0] b0, b1;
      int len;
      do_reset();
      pulse(0, 2'd0, 1'b1);
      pulse(0, 2'd1, 1'b1);
      checks++;
      if (strobe !== 1'b0) begin errors++; $display("FAIL switch_no_strobe: got %b expected 0", strobe); end
      pulse(0, 2'd1, 1'b1);
      checks++;
      if ({strobe, rep} !== 3'b101) begin errors++; $display("FAIL switch_launch: got %b expected 101", {strobe, rep}); end
      get_frame(0, b0, b1, len);
      checks++;
      if (b1 !== 8'h01) begin errors++; $display("FAIL switch_byte1: got %h expected 01", b1); end
      for (int i = 0; i < 4; i++) begin
         pulse(0, 2'd2, 1'b1);
         checks++;
         if (strobe !== 1'b0) begin errors++; $display("FAIL cooldown_pulse%0d: strobe %b expected 0", i, strobe); end
      end
      pulse(0, 2'd2, 1'b1);
      checks++;
      if ({strobe, rep} !== 3'b110) begin errors++; $display("FAIL cooldown_launch: got %b expected 110", {strobe, rep}); end
      get_frame(0, b0, b1, len);
      checks++;
      if (b1 !== 8'h12) begin errors++; $display("FAIL cooldown_byte1: got %h expected 12", b1); end
   endtask

   task automatic test_drop();
      logic [7:0] b0, b1;
      int len;
      do_reset();
      pulse(1, 2'd1, 1'b1);
      pulse(1, 2'd1, 1'b1);
      checks++;
      if (strobe0 !== 1'b1) begin errors++; $display("FAIL drop_first_launch: got %b expected 1", strobe0); end
      fork
         get_frame(1, b0, b1, len);
         begin
            repeat (3) @(negedge clk);
            g0 = 2'd2; p0 = 1'b1; v0 = 1'b1;
            @(negedge clk); v0 = 1'b0;
            repeat (2) @(negedge clk);
            v0 = 1'b1;
            @(negedge clk); v0 = 1'b0;
            checks++;
            if ({dropped0, strobe0} !== 2'b10) begin
               errors++; $display("FAIL drop_pulse: got %b expected 10", {dropped0, strobe0});
            end
            @(negedge clk);
            checks++;
            if (dropped0 !== 1'b0) begin errors++; $display("FAIL drop_width: got %b expected 0", dropped0); end
         end
      join
      checks++;
      if ({b0, b1} !== 16'hA501) begin errors++; $display("FAIL drop_packet: got %h expected a501", {b0, b1}); end
      checks++;
      if (len !== 80) begin errors++; $display("FAIL drop_busy_len: got %0d expected 80", len); end
      pulse(1, 2'd2, 1'b1);
      checks++;
      if ({strobe0, dropped0} !== 2'b00) begin
         errors++; $display("FAIL drop_no_refire: got %b expected 00", {strobe0, dropped0});
      end
      pulse(1, 2'd3, 1'b1);
      pulse(1, 2'd3, 1'b1);
      checks++;
      if (strobe0 !== 1'b1) begin errors++; $display("FAIL drop_second_launch: got %b expected 1", strobe0); end
      get_frame(1, b0, b1, len);
      checks++;
      if (b1 !== 8'h13) begin errors++; $display("FAIL drop_seq_kept: got %h expected 13", b1); end
   endtask

   task automatic test_wrap();
      logic [7:0] b0, b1;
      int len;
      do_reset();
      for (int i = 0; i < 17; i++) begin
         if (i > 0) repeat (3) pulse(0, 2'd2, 1'b0);
         pulse(0, 2'd2, 1'b1);
         pulse(0, 2'd2, 1'b1);
         checks++;
         if (strobe !== 1'b1) begin errors++; $display("FAIL wrap_strobe%0d: got %b expected 1", i, strobe); end
         get_frame(0, b0, b1, len);
         if (i == 15) begin
            checks++;
            if (b1 !== 8'hF2) begin errors++; $display("FAIL wrap_seq15: got %h expected f2", b1); end
         end
         if (i == 16) begin
            checks++;
            if (b1 !== 8'h02) begin errors++; $display("FAIL wrap_seq0: got %h expected 02", b1); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b0, b1;
      int len;
      do_reset();
      pulse(0, 2'd1, 1'b1);
      pulse(0, 2'd1, 1'b1);
      repeat (10) @(negedge clk);
      checks++;
      if ({tx, busy} !== 2'b01) begin errors++; $display("FAIL midreset_before: got %b expected 01", {tx, busy}); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({tx, busy} !== 2'b10) begin errors++; $display("FAIL midreset_after: got %b expected 10", {tx, busy}); end
      pulse(0, 2'd2, 1'b1);
      pulse(0, 2'd2, 1'b1);
      checks++;
      if (strobe !== 1'b1) begin errors++; $display("FAIL midreset_launch: got %b expected 1", strobe); end
      get_frame(0, b0, b1, len);
      checks++;
      if ({b0, b1} !== 16'hA502) begin errors++; $display("FAIL midreset_packet: got %h expected a502", {b0, b1}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_switch_cooldown();
      test_drop();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
